// File: rtl/gate3_exerciser.sv
// gate3_exerciser: drives the three inputs of a 3-input combinational cell
// through all eight codes in Gray order, samples the cell output Q at the end
// of each vector's settle window and compares it with a selectable function
// (OR / AND / XOR / majority). Reports a saturating mismatch count, the Gray
// index of the first mismatch and an overall pass flag.
module gate3_exerciser #(
    parameter int SETTLE_CYCLES = 2,   // 1..255
    parameter int PASSES        = 1,   // 1..15
    parameter int ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic [1:0]       FUNC,
    input  logic             Q,
    output logic             IN1,
    output logic             IN2,
    output logic             IN3,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [2:0]       FIRST_FAIL,
    output logic             FAIL_VALID
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        HOLD,
        SAMPLE
    } state_t;

    // Each vector spends one cycle in APPLY, SETTLE_CYCLES-1 in HOLD and one
    // in SAMPLE, giving SETTLE_CYCLES+1 cycles per vector with no gaps.
    localparam logic [7:0] HOLD_LEN  = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);
    localparam bit         NO_HOLD   = (SETTLE_CYCLES == 1);

    state_t     state_reg;
    logic [2:0] idx_reg;
    logic [3:0] pass_reg;
    logic [7:0] cnt_reg;
    logic [1:0] func_reg;
    logic [2:0] vec_reg;

    logic             expected;
    logic             mismatch;
    logic             last_step;
    logic [2:0]       idx_next;
    logic [2:0]       vec_next;
    logic [ERR_W-1:0] err_sat;
    logic [ERR_W-1:0] err_after;

    // Expected cell output for the vector currently driven, plus the
    // saturating error increment and the Gray code of the next index.
    always_comb begin
        expected = 1'b0;
        case (func_reg)
            2'b00:   expected = |vec_reg;
            2'b01:   expected = &vec_reg;
            2'b10:   expected = ^vec_reg;
            default: expected = (vec_reg[0] & vec_reg[1]) |
                                (vec_reg[0] & vec_reg[2]) |
                                (vec_reg[1] & vec_reg[2]);
        endcase
        mismatch  = (Q != expected);
        last_step = (idx_reg == 3'd7) && (pass_reg == LAST_PASS);
        idx_next  = idx_reg + 3'd1;
        vec_next  = idx_next ^ (idx_next >> 1);
        err_sat   = (&ERR_CNT) ? ERR_CNT : ERR_CNT + {{(ERR_W-1){1'b0}}, 1'b1};
        err_after = mismatch ? err_sat : ERR_CNT;
    end

    assign IN1 = vec_reg[0];
    assign IN2 = vec_reg[1];
    assign IN3 = vec_reg[2];

    // Sequencer: run control, vector stepping and result accumulation.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_reg  <= IDLE;
            idx_reg    <= 3'd0;
            pass_reg   <= 4'd0;
            cnt_reg    <= 8'd0;
            func_reg   <= 2'b00;
            vec_reg    <= 3'b000;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FIRST_FAIL <= 3'd0;
            FAIL_VALID <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        func_reg   <= FUNC;
                        ERR_CNT    <= '0;
                        PASS       <= 1'b0;
                        FIRST_FAIL <= 3'd0;
                        FAIL_VALID <= 1'b0;
                        idx_reg    <= 3'd0;
                        pass_reg   <= 4'd0;
                        vec_reg    <= 3'b000;
                        BUSY       <= 1'b1;
                        state_reg  <= APPLY;
                    end
                end
                APPLY: begin
                    cnt_reg   <= HOLD_LEN;
                    state_reg <= NO_HOLD ? SAMPLE : HOLD;
                end
                HOLD: begin
                    if (cnt_reg <= 8'd1) begin
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: begin
                    if (mismatch) begin
                        ERR_CNT <= err_sat;
                        if (!FAIL_VALID) begin
                            FIRST_FAIL <= idx_reg;
                            FAIL_VALID <= 1'b1;
                        end
                    end
                    if (last_step) begin
                        state_reg <= IDLE;
                        vec_reg   <= 3'b000;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        PASS      <= (err_after == '0);
                    end else begin
                        idx_reg   <= idx_next;
                        vec_reg   <= vec_next;
                        state_reg <= APPLY;
                        if (idx_reg == 3'd7) begin
                            pass_reg <= pass_reg + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/gate3_exerciser.md
# gate3_exerciser

Sequential stimulus-and-check engine that drives the three inputs of a 3-input combinational cell under test and samples its single output. It steps through all eight input codes in Gray order, so exactly one input toggles per step. Each sampled output is compared against a selectable expected function. It sits beside the standard-cell instances in the power/characterisation harness as the driving end of the cells' IN1/IN2/IN3 → Q interface.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before Q is sampled; legal range 1..255.
- PASSES, 1, number of full 8-vector sweeps per run; legal range 1..15.
- ERR_W, 8, width of the mismatch counter.

- CLK  in  1  single clock; all state updates on rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- START  in  1  run request; accepted only in IDLE.
- FUNC  in  2  expected function: 00 OR, 01 AND, 10 XOR, 11 majority; captured at START.
- Q  in  1  output of the cell under test.
- IN1  out  1  cell input 1 (LSB of vector code).
- IN2  out  1  cell input 2.
- IN3  out  1  cell input 3 (MSB).
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse at end of run.
- PASS  out  1  last completed run had zero mismatches.
- ERR_CNT  out  ERR_W  mismatch count, saturating.
- FIRST_FAIL  out  3  Gray index (0..7) of the first mismatching vector.
- FAIL_VALID  out  1  FIRST_FAIL holds a captured value.

## Operation
- Gray sequence, index→{IN3,IN2,IN1}: 0:000, 1:001, 2:011, 3:010, 4:110, 5:111, 6:101, 7:100.
- FSM states:
  - IDLE: START → APPLY.
  - APPLY: drive the vector and load the settle counter, then go to HOLD.
  - HOLD: count down; at terminal count go to SAMPLE.
  - SAMPLE: compare Q with expected. If this was the last index of the last pass, go to IDLE with the DONE pulse; otherwise advance the index (7 wraps to 0 and increments the pass counter) and go to APPLY.
- Each vector is held for exactly SETTLE_CYCLES+1 cycles, with no gap between vectors.
- On START: capture FUNC; clear ERR_CNT, PASS, FAIL_VALID and FIRST_FAIL.
- On mismatch:
  - ERR_CNT increments and saturates at 2^ERR_W−1.
  - If FAIL_VALID=0, FIRST_FAIL takes the current index and FAIL_VALID is set.
  - Once set, FIRST_FAIL and FAIL_VALID are held for the rest of the run.
- PASS is set with DONE when ERR_CNT=0. PASS, ERR_CNT, FIRST_FAIL and FAIL_VALID hold until the next accepted START.
- IN1..IN3 are 000 whenever the FSM is in IDLE.
- START while BUSY=1 is ignored; it is neither queued nor allowed to restart the run.
- START in the DONE-pulse cycle is accepted, because the FSM is already in IDLE.
- All outputs are registered; no combinational path from Q or START to any output.

## Timing
- Reset values of all outputs are 0: IN1..IN3 = 000, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_VALID.
- RSTB assertion forces reset values immediately, including mid-run. After release the FSM stays in IDLE until START.
- Let E0 be the edge that samples START=1. Just after E0: BUSY=1 and IN = vector 0.
- Vector n (global step n = 0..8·PASSES−1) is driven from E0+n·(S+1) to E0+(n+1)·(S+1), where S = SETTLE_CYCLES.
- Q for vector n is sampled at edge E0+(n+1)·(S+1), using the value before the outputs change.
- After edge E0+8·PASSES·(S+1):
  - BUSY=0 and DONE=1 for one cycle.
  - IN = 000.
  - ERR_CNT, PASS and FIRST_FAIL are final.
- Run latency is 8·PASSES·(S+1) cycles from START to DONE.

## Test plan
- S=2, P=1, FUNC=00, Q modelled as OR of inputs → DONE 24 cycles after START; ERR_CNT=0, PASS=1, FAIL_VALID=0; IN sequence follows the Gray order with 3 cycles per vector.
- FUNC=00, Q modelled as AND → ERR_CNT=6, FIRST_FAIL=1, FAIL_VALID=1, PASS=0.
- FUNC=10, Q stuck at 0 → ERR_CNT=4 (indices 1, 3, 5, 7), FIRST_FAIL=1, PASS=0.
- ERR_W=2, P=3, FUNC=01, Q stuck at 1 → 21 raw mismatches; ERR_CNT saturates at 3; DONE after 72 cycles.
- RSTB pulsed low during step 3 → all outputs 0 immediately, no DONE pulse; after release, IN stays 000 and BUSY=0 until a new START.
- START re-asserted 5 cycles into a run → ignored, DONE still at cycle 24. START in the DONE-pulse cycle → new run starts, ERR_CNT cleared.
